// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide over 32 cycles.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a combinational multiplier.
module rv32m_muldiv_unit #(
   parameter int WIDTH     = 32,
   parameter int REG_COUNT = 32,
   parameter int REG_BITS  = $clog2(REG_COUNT)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic [2:0]          funct3,
   input  logic [WIDTH-1:0]    rs1_data,
   input  logic [WIDTH-1:0]    rs2_data,
   input  logic [REG_BITS-1:0] rd,
   input  logic                flush,
   output logic                busy,
   output logic                done,
   output logic                wb_en,
   output logic [REG_BITS-1:0] wb_reg,
   output logic [WIDTH-1:0]    wb_data
);

   // state | meaning
   // IDLE  | waiting for start
   // CALC  | one multiply/divide iteration per cycle
   // DONE  | result presented for one cycle
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int CW = $clog2(WIDTH) + 1;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [REG_BITS-1:0] rd_q, rd_d;
   logic                sign_q, sign_d;
   logic [WIDTH-1:0]    divisor_q, divisor_d;
   logic [2*WIDTH-1:0]  acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                wb_en_q, wb_en_d;
   logic [REG_BITS-1:0] wb_reg_q, wb_reg_d;
   logic [WIDTH-1:0]    wb_data_q, wb_data_d;

   logic               is_div, a_signed, b_signed, a_neg, b_neg, b_zero, ovf;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, step;

   assign is_div   = funct3[2];
   assign a_signed = !(funct3[0] && (funct3[1] || funct3[2]));
   assign b_signed = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
   assign a_neg    = a_signed && rs1_data[WIDTH-1];
   assign b_neg    = b_signed && rs2_data[WIDTH-1];
   assign a_mag    = a_neg ? -rs1_data : rs1_data;
   assign b_mag    = b_neg ? -rs2_data : rs2_data;
   assign b_zero   = (rs2_data == '0);
   assign ovf      = (rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_data == '1);

`ifdef MULDIV_FAST_MUL_EN
   // Operands extended past 33 bits; the low 2*WIDTH bits equal the 33x33 signed product.
   logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;
   assign a_ext     = {{WIDTH{a_signed && rs1_data[WIDTH-1]}}, rs1_data};
   assign b_ext     = {{WIDTH{b_signed && rs2_data[WIDTH-1]}}, rs2_data};
   assign fast_prod = a_ext * b_ext;
`endif

   function automatic logic [WIDTH-1:0] finalize(input logic [2:0] op, input logic sgn,
                                                 input logic [2*WIDTH-1:0] v);
      logic [2*WIDTH-1:0] full;
      logic [WIDTH-1:0]   sel;
      full = sgn ? -v : v;
      sel  = op[1] ? v[2*WIDTH-1:WIDTH] : v[WIDTH-1:0];
      if (op[2]) finalize = sgn ? -sel : sel;
      else       finalize = (op[1:0] == 2'd0) ? full[WIDTH-1:0] : full[2*WIDTH-1:WIDTH];
   endfunction

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      sign_d    = sign_q;
      divisor_d = divisor_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      wb_en_d   = 1'b0;
      wb_reg_d  = wb_reg_q;
      wb_data_d = wb_data_q;

      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
      mul_nxt   = {mul_sum, acc_q[WIDTH-1:1]};
      // Trial subtraction on the remainder shifted left by one (WIDTH+1 bits).
      div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, divisor_q};
      div_nxt   = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      step      = op_q[2] ? div_nxt : mul_nxt;

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d   = funct3;
               rd_d   = rd;
               sign_d = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
               cnt_d  = CW'(WIDTH - 1);
               if (is_div && b_zero) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  wb_en_d   = (rd != '0);
                  wb_reg_d  = rd;
                  wb_data_d = funct3[1] ? rs1_data : '1;
               end else if (is_div && !funct3[0] && ovf) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  wb_en_d   = (rd != '0);
                  wb_reg_d  = rd;
                  wb_data_d = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!is_div) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  wb_en_d   = (rd != '0);
                  wb_reg_d  = rd;
                  wb_data_d = (funct3[1:0] == 2'd0) ? fast_prod[WIDTH-1:0]
                                                    : fast_prod[2*WIDTH-1:WIDTH];
               end
`endif
               else begin
                  state_d   = CALC;
                  divisor_d = is_div ? b_mag : a_mag;
                  acc_d     = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
               end
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               acc_d = step;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  wb_en_d   = (rd_q != '0);
                  wb_reg_d  = rd_q;
                  wb_data_d = finalize(op_q, sign_q, step);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         sign_q    <= 1'b0;
         divisor_q <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_reg_q  <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         sign_q    <= sign_d;
         divisor_q <= divisor_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         wb_en_q   <= wb_en_d;
         wb_reg_q  <= wb_reg_d;
         wb_data_q <= wb_data_d;
      end
   end

   // A flush landing on the DONE cycle must suppress the already-registered writeback.
   assign busy    = (state_q != IDLE);
   assign done    = done_q && !flush;
   assign wb_en   = wb_en_q && !flush;
   assign wb_reg  = wb_reg_q;
   assign wb_data = wb_data_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed vector bench for rv32m_muldiv_unit, including handshake, flush and reset corners.
module tb_rv32m_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1_data = '0, rs2_data = '0;
   logic [4:0]  rd = '0;
   logic        flush = 1'b0;
   logic        busy, done, wb_en;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   rv32m_muldiv_unit dut (
      .clk(clk), .rstn(rstn), .start(start), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .flush(flush),
      .busy(busy), .done(done), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  r;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Returns at cycle T+1 (+1 time unit), with start already deasserted.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
      @(posedge clk); #1;
      funct3 = f; rs1_data = a; rs2_data = b; rd = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int lat, ndone, first;
      vecs[0]  = '{3'd0, 32'h7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, ML};
      vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, ML};
      vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, ML};
      vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h2,        5'd8,  32'hFFFFFFFF, ML};
      vecs[4]  = '{3'd2, 32'h2,        32'hFFFFFFFF, 5'd9,  32'h1,        ML};
      vecs[5]  = '{3'd0, 32'h10000,    32'h10000,    5'd10, 32'h0,        ML};
      vecs[6]  = '{3'd1, 32'h7,        32'hFFFFFFFD, 5'd11, 32'hFFFFFFFF, ML};
      vecs[7]  = '{3'd4, 32'hFFFFFFF9, 32'h2,        5'd12, 32'hFFFFFFFD, 33};
      vecs[8]  = '{3'd6, 32'hFFFFFFF9, 32'h2,        5'd13, 32'hFFFFFFFF, 33};
      vecs[9]  = '{3'd5, 32'd100,      32'd7,        5'd14, 32'd14,       33};
      vecs[10] = '{3'd7, 32'd100,      32'd7,        5'd15, 32'd2,        33};
      vecs[11] = '{3'd4, 32'h7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 33};
      vecs[12] = '{3'd6, 32'h7,        32'hFFFFFFFE, 5'd17, 32'h1,        33};
      vecs[13] = '{3'd5, 32'd100,      32'd0,        5'd18, 32'hFFFFFFFF, 1};
      vecs[14] = '{3'd7, 32'd100,      32'd0,        5'd19, 32'd100,      1};
      vecs[15] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000, 1};
      vecs[16] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h0,        1};
      vecs[17] = '{3'd6, 32'hFFFFFFFB, 32'd0,        5'd22, 32'hFFFFFFFB, 1};
      vecs[18] = '{3'd4, 32'd100,      32'd7,        5'd0,  32'd14,       33};
      vecs[19] = '{3'd5, 32'hFFFFFFFF, 32'h1,        5'd23, 32'hFFFFFFFF, 33};
      vecs[20] = '{3'd7, 32'hFFFFFFFF, 32'h80000000, 5'd24, 32'h7FFFFFFF, 33};

      #12;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
      chk("reset_wb_data", wb_data, 32'd0);
      chk("reset_wb_reg", {27'd0, wb_reg}, 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < 21; i++) begin
         issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r);
         chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
         wait_done(lat);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp);
         chk($sformatf("v%0d_wb_reg", i), {27'd0, wb_reg}, {27'd0, vecs[i].r});
         chk($sformatf("v%0d_wb_en", i), {31'd0, wb_en}, {31'd0, vecs[i].r != 5'd0});
         @(posedge clk); #1;
         chk($sformatf("v%0d_busy_drop", i), {31'd0, busy}, 32'd0);
      end

      // start pulses at T+5 and in the DONE cycle T+33 must be ignored
      issue(3'd5, 32'd100, 32'd7, 5'd3);
      ndone = 0; first = 0;
      for (int k = 1; k <= 45; k++) begin
         if (done) begin
            ndone++;
            if (first == 0) first = k;
         end
         if (k == 34) chk("ign_busy_t34", {31'd0, busy}, 32'd0);
         if (k == 5 || k == 33) begin
            funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd = 5'd9; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("ign_done_count", ndone, 1);
      chk("ign_done_cycle", first, 33);
      chk("ign_wb_data", wb_data, 32'd14);

      // flush at T+10 of a DIV
      issue(3'd4, 32'd1000, 32'd3, 5'd4);
      ndone = 0;
      for (int k = 1; k <= 40; k++) begin
         if (done || wb_en) ndone++;
         if (k == 11) chk("flush_idle_t11", {31'd0, busy}, 32'd0);
         flush = (k == 10);
         @(posedge clk); #1;
      end
      flush = 1'b0;
      chk("flush_no_done", ndone, 0);

      // flush coinciding with DONE
      issue(3'd5, 32'd100, 32'd7, 5'd6);
      repeat (32) begin @(posedge clk); #1; end
      chk("fdone_state", {31'd0, busy}, 32'd1);
      flush = 1'b1; #1;
      chk("fdone_done", {31'd0, done}, 32'd0);
      chk("fdone_wb_en", {31'd0, wb_en}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fdone_idle", {31'd0, busy}, 32'd0);

      // start together with flush in IDLE is ignored
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; funct3 = 3'd5;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("sflush_busy", {31'd0, busy}, 32'd0);

      // asynchronous reset mid-CALC
      issue(3'd5, 32'd100, 32'd7, 5'd7);
      repeat (4) begin @(posedge clk); #1; end
      rstn = 1'b0; #1;
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      chk("rst_mid_wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst_mid_wb_data", wb_data, 32'd0);
      #2 rstn = 1'b1;
      issue(3'd7, 32'd100, 32'd7, 5'd8);
      wait_done(lat);
      chk("rst_after_latency", lat, 33);
      chk("rst_after_wb_data", wb_data, 32'd2);
      chk("rst_after_wb_en", {31'd0, wb_en}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
